// File: rtl/kara_div_pkg.sv
// Shared widths and state encoding for the 66/33 sequential restoring divider.
package kara_div_pkg;

    localparam int unsigned DIV_DW = 33;
    localparam int unsigned DIV_NW = 2 * DIV_DW;
    localparam int unsigned DIV_CW = $clog2(DIV_NW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/kara_div66by33_seq_if.sv
// Operand/result valid-ready bundle between a requester (master) and the divider (slave).
interface kara_div66by33_seq_if #(
    parameter int unsigned DW = 33,
    parameter int unsigned NW = 2 * DW
) ();

    logic          in_valid;
    logic          in_ready;
    logic [NW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [NW-1:0] quotient;
    logic [DW-1:0] remainder;
    logic          div_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero
    );

endinterface

// File: rtl/kara_div_step.sv
// One combinational restoring step: shift in the next dividend bit, trial-subtract, restore on borrow.
module kara_div_step #(
    parameter int unsigned DW = 33
) (
    input  logic [DW:0]   r_in,
    input  logic          q_msb_in,
    input  logic [DW-1:0] divisor,
    output logic [DW:0]   r_out_c,
    output logic          q_bit_c
);

    // Two guard bits above the shifted remainder make the compare exact.
    logic [DW+2:0] ext_c;
    logic [DW+2:0] dvs_c;

    assign ext_c   = {1'b0, r_in, q_msb_in};
    assign dvs_c   = {3'b000, divisor};
    assign q_bit_c = (ext_c >= dvs_c);
    assign r_out_c = q_bit_c ? (DW+1)'(ext_c - dvs_c) : ext_c[DW:0];

endmodule

// File: rtl/kara_div66by33_seq.sv
// Sequential restoring divider NW/DW -> quotient NW, remainder DW, valid/ready on both sides.
// Build option: define DIV_RADIX4_EN to retire two quotient bits per RUN cycle.
module kara_div66by33_seq
    import kara_div_pkg::*;
#(
    parameter int unsigned DW = DIV_DW,
    parameter int unsigned NW = 2 * DW
) (
    input logic                  clk,
    input logic                  rst,
    kara_div66by33_seq_if.slave  bus
);

    localparam int unsigned CW = $clog2(NW);
`ifdef DIV_RADIX4_EN
    localparam logic [CW-1:0] CNT_LOAD = CW'(NW / 2 - 1);
`else
    localparam logic [CW-1:0] CNT_LOAD = CW'(NW - 1);
`endif

    div_state_t    state, state_nx;
    logic [DW:0]   r_q, r_nx;
    logic [NW-1:0] q_q, q_nx;
    logic [CW-1:0] cnt_q, cnt_nx;
    logic [DW-1:0] dvs_q, dvs_nx;
    logic [DW-1:0] lo_q, lo_nx;
    logic          dz_q, dz_nx;

    logic          in_ready_q, in_ready_nx;
    logic          out_valid_q, out_valid_nx;
    logic [NW-1:0] quotient_q, quotient_nx;
    logic [DW-1:0] remainder_q, remainder_nx;
    logic          div_zero_q, div_zero_nx;

    logic          accept_c;
    logic          out_hs_c;
    logic [DW:0]   step_r_c;
    logic [NW-1:0] step_q_c;
    logic [DW:0]   r0_c;
    logic          qb0_c;

    assign accept_c = (state == IDLE) && bus.in_valid && in_ready_q;
    assign out_hs_c = out_valid_q && bus.out_ready;

    kara_div_step #(.DW(DW)) u_step0 (
        .r_in     (r_q),
        .q_msb_in (q_q[NW-1]),
        .divisor  (dvs_q),
        .r_out_c  (r0_c),
        .q_bit_c  (qb0_c)
    );

`ifdef DIV_RADIX4_EN
    logic [DW:0] r1_c;
    logic        qb1_c;

    kara_div_step #(.DW(DW)) u_step1 (
        .r_in     (r0_c),
        .q_msb_in (q_q[NW-2]),
        .divisor  (dvs_q),
        .r_out_c  (r1_c),
        .q_bit_c  (qb1_c)
    );

    assign step_r_c = r1_c;
    assign step_q_c = {q_q[NW-3:0], qb0_c, qb1_c};
`else
    assign step_r_c = r0_c;
    assign step_q_c = {q_q[NW-2:0], qb0_c};
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept_c)      state_nx = RUN;
            RUN:     if (cnt_q == '0)   state_nx = DONE;
            DONE:    if (out_hs_c)      state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    // Datapath and output next values; results are loaded once on the first DONE cycle.
    always_comb begin
        r_nx         = r_q;
        q_nx         = q_q;
        cnt_nx       = cnt_q;
        dvs_nx       = dvs_q;
        lo_nx        = lo_q;
        dz_nx        = dz_q;
        out_valid_nx = out_valid_q;
        quotient_nx  = quotient_q;
        remainder_nx = remainder_q;
        div_zero_nx  = div_zero_q;
        in_ready_nx  = (state_nx == IDLE);
        unique case (state)
            IDLE: begin
                if (accept_c) begin
                    r_nx   = '0;
                    q_nx   = bus.dividend;
                    cnt_nx = CNT_LOAD;
                    dvs_nx = bus.divisor;
                    lo_nx  = bus.dividend[DW-1:0];
                    dz_nx  = (bus.divisor == '0);
                end
            end
            RUN: begin
                r_nx = step_r_c;
                q_nx = step_q_c;
                if (cnt_q != '0) cnt_nx = cnt_q - CW'(1);
            end
            DONE: begin
                if (!out_valid_q) begin
                    out_valid_nx = 1'b1;
                    quotient_nx  = dz_q ? '1   : q_q;
                    remainder_nx = dz_q ? lo_q : r_q[DW-1:0];
                    div_zero_nx  = dz_q;
                end else if (out_hs_c) begin
                    out_valid_nx = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q         <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
            dvs_q       <= '0;
            lo_q        <= '0;
            dz_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            r_q         <= r_nx;
            q_q         <= q_nx;
            cnt_q       <= cnt_nx;
            dvs_q       <= dvs_nx;
            lo_q        <= lo_nx;
            dz_q        <= dz_nx;
            in_ready_q  <= in_ready_nx;
            out_valid_q <= out_valid_nx;
            quotient_q  <= quotient_nx;
            remainder_q <= remainder_nx;
            div_zero_q  <= div_zero_nx;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.div_zero  = div_zero_q;

endmodule

// File: tb/tb_kara_div66by33_seq.sv
// Bench for kara_div66by33_seq: directed literal cases plus random operands against an arithmetic model.
module tb_kara_div66by33_seq;
    import kara_div_pkg::*;

    localparam int unsigned DW = DIV_DW;
    localparam int unsigned NW = DIV_NW;
`ifdef DIV_RADIX4_EN
    localparam int LAT = NW / 2 + 1;
`else
    localparam int LAT = NW + 1;
`endif

    typedef struct {
        logic [NW-1:0] q;
        logic [DW-1:0] r;
        logic          dz;
        int            acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   seen = 0;
    exp_t exp_q[$];

    kara_div66by33_seq_if #(.DW(DW), .NW(NW)) bus ();

    kara_div66by33_seq #(.DW(DW), .NW(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [NW-1:0] got, input logic [NW-1:0] want);
        total = total + 1;
        if (got !== want) begin
            bad = bad + 1;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Unsigned division as the arithmetic definition, with the divide-by-zero convention.
    function automatic exp_t model(input logic [NW-1:0] a, input logic [DW-1:0] b);
        exp_t e;
        logic [NW-1:0] bw;
        bw = NW'(b);
        if (b == '0) begin
            e.q  = '1;
            e.r  = a[DW-1:0];
            e.dz = 1'b1;
        end else begin
            e.q  = a / bw;
            e.r  = DW'(a % bw);
            e.dz = 1'b0;
        end
        e.acc = 0;
        return e;
    endfunction

    // Compare outputs against the model every cycle they are valid; predict handshakes for the next edge.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
            seen = 0;
        end else begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 1'b1, 1'b0);
                end else begin
                    e = exp_q[0];
                    check("cmp_quotient", bus.quotient, e.q);
                    check("cmp_remainder", NW'(bus.remainder), NW'(e.r));
                    check("cmp_div_zero", NW'(bus.div_zero), NW'(e.dz));
                    check("cmp_in_ready_busy", NW'(bus.in_ready), '0);
                    if (!seen) begin
                        check("cmp_latency", NW'(cyc - e.acc), NW'(LAT));
                        seen = 1;
                    end
                end
                if (bus.out_ready && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    seen = 0;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e = model(bus.dividend, bus.divisor);
                e.acc = cyc + 1;
                exp_q.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [NW-1:0] a, input logic [DW-1:0] b);
        int n = 0;
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("accept_timeout", 1'b0, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        bus.dividend = ~a;
        bus.divisor  = ~b;
    endtask

    task automatic wait_out();
        int n = 0;
        while (!bus.out_valid && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("out_valid_timeout", 1'b0, 1'b1);
    endtask

    task automatic drain(input int hold);
        repeat (hold) tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("post_hs_out_valid", NW'(bus.out_valid), '0);
        check("post_hs_in_ready", NW'(bus.in_ready), NW'(1));
    endtask

    task automatic run(input logic [NW-1:0] a, input logic [DW-1:0] b,
                       input logic [NW-1:0] eq, input logic [DW-1:0] er, input logic edz,
                       input int hold);
        send(a, b);
        wait_out();
        check("lit_quotient", bus.quotient, eq);
        check("lit_remainder", NW'(bus.remainder), NW'(er));
        check("lit_div_zero", NW'(edz), NW'(bus.div_zero));
        if (hold > 0) begin
            repeat (hold) tick();
            check("hold_out_valid", NW'(bus.out_valid), NW'(1));
            check("hold_in_ready", NW'(bus.in_ready), '0);
            check("hold_quotient", bus.quotient, eq);
            check("hold_remainder", NW'(bus.remainder), NW'(er));
        end
        drain(0);
    endtask

    initial begin
        logic [NW-1:0] a;
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic [NW-1:0] all1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        all1          = '1;

        repeat (3) tick();
        rst = 1'b0;
        check("rst_in_ready", NW'(bus.in_ready), NW'(1));
        check("rst_out_valid", NW'(bus.out_valid), '0);
        check("rst_quotient", bus.quotient, '0);
        check("rst_remainder", NW'(bus.remainder), '0);
        check("rst_div_zero", NW'(bus.div_zero), '0);

        run(NW'(1000), DW'(7), NW'(142), DW'(6), 1'b0, 0);
        run(all1, DW'(1), all1, DW'(0), 1'b0, 0);
        run(66'h3_FFFF_FFFC_0000_0001, 33'h1_FFFF_FFFF, NW'(33'h1_FFFF_FFFF), DW'(0), 1'b0, 0);
        run(66'h5_0000_0000_1234_5678, DW'(0), all1, 33'h0_1234_5678, 1'b1, 0);
        run(NW'(1000), DW'(7), NW'(142), DW'(6), 1'b0, 10);

        // Abort a division in flight, then confirm a clean restart.
        send(NW'(1000), DW'(7));
        repeat (20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_out_valid", NW'(bus.out_valid), '0);
        check("abort_in_ready", NW'(bus.in_ready), NW'(1));
        check("abort_quotient", bus.quotient, '0);
        run(NW'(1000), DW'(7), NW'(142), DW'(6), 1'b0, 0);

        for (int i = 0; i < 400; i++) begin
            x = DW'({$urandom, $urandom});
            y = DW'({$urandom, $urandom});
            a = NW'({$urandom, $urandom, $urandom});
            case ($urandom_range(0, 3))
                0: send(a, y);
                1: send(NW'(x) * NW'(y), y);
                2: send(NW'(x) * NW'(y), DW'(x + DW'($urandom_range(0, 3))));
                default: send(a, DW'($urandom_range(0, 15)));
            endcase
            wait_out();
            drain($urandom_range(0, 2));
        end

        tick();
        check("final_queue_empty", NW'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
